// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Scans a 4x4 active-low matrix keypad one column at a time, assembles a full
// 16-bit frame of pressed keys, and accepts a frame only after it has been seen
// identically for DEBOUNCE_SCANS consecutive frames. The accepted result is a
// one-hot key code, or zero for "no key" as well as for multi-press/ghosting.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS) + 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [DW-1:0] dwell_cnt;
  logic [15:0]   frame;
  logic [15:0]   prev_frame;
  logic [15:0]   frame_next;
  logic [15:0]   col_mask;
  logic [15:0]   col_bits;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_next;
  logic [15:0]   key_next;
  logic          last_dwell;
  logic          frame_done;
  logic          single_key;
  logic          accept;

  // The column currently being driven low follows the scan state directly.
  assign col = ~(4'b0001 << state);

  assign last_dwell = (dwell_cnt == DWELL_LAST);
  assign frame_done = last_dwell && (state == COL3);

  // Row readings for the driven column land on bits r*4+c of the frame.
  assign col_mask = 16'h1111 << state;
  assign col_bits = {3'b000, ~row[3], 3'b000, ~row[2],
                     3'b000, ~row[1], 3'b000, ~row[0]} << state;

  // Next scan state: walk the four columns in order and wrap.
  always_comb begin
    state_next = state;
    case (state)
      COL0:    state_next = COL1;
      COL1:    state_next = COL2;
      COL2:    state_next = COL3;
      COL3:    state_next = COL0;
      default: state_next = COL0;
    endcase
  end

  // Frame with the current column's sample merged in, plus debounce decision.
  always_comb begin
    frame_next  = frame;
    stable_next = '0;
    if (last_dwell) begin
      frame_next = (frame & ~col_mask) | (col_bits & col_mask);
    end
    if (frame_next == prev_frame) begin
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
    end
    single_key = (frame_next != 16'h0000) &&
                 ((frame_next & (frame_next - 16'd1)) == 16'h0000);
    key_next   = single_key ? frame_next : 16'h0000;
    accept     = frame_done && (stable_next == STABLE_MAX);
  end

  // Dwell counter and column state; rows settle for the whole dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COL0;
      dwell_cnt <= '0;
    end else if (last_dwell) begin
      state     <= state_next;
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Frame assembly and frame-to-frame stability tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame      <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
    end else begin
      frame <= frame_next;
      if (frame_done) begin
        prev_frame <= frame_next;
        stable_cnt <= stable_next;
      end
    end
  end

  // Output register: updates only on accept, so bounce can never glitch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot    <= '0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (accept) begin
        onehot    <= key_next;
        key_valid <= (key_next != 16'h0000);
        key_pulse <= (key_next != 16'h0000) && (key_next != onehot);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce
// Directed keypad scenarios followed by random key activity. A keypad model
// drives row from col and a frame-level reference tracks the expected outputs.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int F              = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;

  logic [15:0] keys;
  logic [15:0] shifted;

  int          checks = 0;
  int          errors = 0;
  int          m = 0;
  logic [15:0] mframe;
  logic [15:0] hist[$];
  logic [15:0] exp_onehot;
  logic        exp_valid;
  logic        exp_pulse;

  keypad_scan_debounce #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    shifted = 16'h0000;
    case (col)
      4'b1110: shifted = keys;
      4'b1101: shifted = keys >> 1;
      4'b1011: shifted = keys >> 2;
      4'b0111: shifted = keys >> 3;
      default: shifted = 16'h0000;
    endcase
    row = ~{shifted[12], shifted[8], shifted[4], shifted[0]};
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, m, obs, exp);
    end
  endtask

  // Reference: frames are whatever the keys were at each column's last dwell
  // cycle; a frame is accepted once the last DEBOUNCE_SCANS frames (with an
  // all-zero frame standing in before the first) are identical.
  task automatic updateModel();
    int  c;
    bit  same;
    logic [15:0] newv;
    if (!rst_n) begin
      m          = 0;
      mframe     = 16'h0000;
      hist       = {16'h0000};
      exp_onehot = 16'h0000;
      exp_valid  = 1'b0;
      exp_pulse  = 1'b0;
    end else begin
      m++;
      exp_pulse = 1'b0;
      if (m % SCAN_DIV == 0) begin
        c = ((m - 1) / SCAN_DIV) % 4;
        mframe = (mframe & ~(16'h1111 << c)) | (keys & (16'h1111 << c));
        if (c == 3) begin
          hist.push_back(mframe);
          if (hist.size() > DEBOUNCE_SCANS) void'(hist.pop_front());
          same = (hist.size() == DEBOUNCE_SCANS);
          foreach (hist[i]) if (hist[i] != mframe) same = 1'b0;
          if (same) begin
            newv       = ($countones(mframe) == 1) ? mframe : 16'h0000;
            exp_pulse  = (newv != 16'h0000) && (newv != exp_onehot);
            exp_onehot = newv;
            exp_valid  = (newv != 16'h0000);
          end
        end
      end
    end
  endtask

  task automatic stepCycle();
    logic [3:0] exp_col;
    @(posedge clk);
    @(negedge clk);
    updateModel();
    exp_col = ~(4'b0001 << ((m / SCAN_DIV) % 4));
    checkOutput("col", {12'h000, col}, {12'h000, exp_col});
    checkOutput("onehot", onehot, exp_onehot);
    checkOutput("key_valid", {15'h0000, key_valid}, {15'h0000, exp_valid});
    checkOutput("key_pulse", {15'h0000, key_pulse}, {15'h0000, exp_pulse});
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) stepCycle();
  endtask

  initial begin
    logic [15:0] rk;
    rst_n = 1'b0;
    keys  = 16'h0000;

    // 1: reset held five cycles, then idle scanning with no key.
    applyStimulus(16'h0000, 5);
    rst_n = 1'b1;
    applyStimulus(16'h0000, 2 * F);
    checkOutput("t1_onehot", onehot, 16'h0000);

    // 2: clean press of (r1,c3), held, then released.
    applyStimulus(16'h0080, 5 * F);
    checkOutput("t2_onehot", onehot, 16'h0080);
    applyStimulus(16'h0000, 4 * F);
    checkOutput("t2_release", onehot, 16'h0000);

    // 3: (r0,c3) bouncing on alternate frames, then stable.
    applyStimulus(16'h0008, F);
    applyStimulus(16'h0000, F);
    applyStimulus(16'h0008, F);
    applyStimulus(16'h0000, F);
    checkOutput("t3_bounce", onehot, 16'h0000);
    applyStimulus(16'h0008, 4 * F);
    checkOutput("t3_onehot", onehot, 16'h0008);

    // 4: two keys held together, then one released.
    applyStimulus(16'h0420, 4 * F);
    checkOutput("t4_ghost", onehot, 16'h0000);
    applyStimulus(16'h0020, 4 * F);
    checkOutput("t4_single", onehot, 16'h0020);

    // 5: direct switch 0x0040 -> (r3,c1) without release, then release.
    applyStimulus(16'h0040, 4 * F);
    applyStimulus(16'h2000, 4 * F);
    checkOutput("t5_switch", onehot, 16'h2000);
    applyStimulus(16'h0000, 4 * F);
    checkOutput("t5_release", onehot, 16'h0000);

    // 6: reset during COL2 with a valid key held, then re-acceptance.
    applyStimulus(16'h0040, 4 * F + 9);
    rst_n = 1'b0;
    applyStimulus(16'h0040, 1);
    checkOutput("t6_reset", onehot, 16'h0000);
    rst_n = 1'b1;
    applyStimulus(16'h0040, 4 * F);
    checkOutput("t6_reaccept", onehot, 16'h0040);

    // Random key activity with mid-frame changes and occasional resets.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0:       rk = 16'h0000;
        3:       rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: rk = 16'h0001 << $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        applyStimulus(rk, 1);
        rst_n = 1'b1;
      end
      applyStimulus(rk, $urandom_range(1, 5 * F));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
